// File: rtl/freq_seq_pkg.sv
// freq_seq_pkg: shared states, digit constants and the BCD adjust helper for the frequency sequencer
package freq_seq_pkg;
  localparam int BCD_DIGITS = 4;
  localparam int NIB_W = 4;
  localparam int MAX_COUNT = 9999;
  localparam int BCD_W = BCD_DIGITS * NIB_W;
  typedef enum logic [2:0] {IDLE, GATE, LATCH, CONVERT, PUBLISH} state_t;
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (v[i*NIB_W +: NIB_W] >= 4'd5) r[i*NIB_W +: NIB_W] = v[i*NIB_W +: NIB_W] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 converter, one bit per cycle, done pulses as the last digit settles
module bin2bcd_seq
  import freq_seq_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);
  localparam int IW = $clog2(CNT_W + 1);
  logic [CNT_W-1:0] sh;
  logic [IW-1:0] left;
  logic [BCD_W+CNT_W-1:0] nxt;
  assign nxt = {add3(bcd), sh} << 1;
  // the load cycle already performs the first shift (adjusting an all-zero BCD is a no-op)
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      bcd <= '0;
      sh <= '0;
      left <= '0;
      done <= 1'b0;
    end else if (load) begin
      bcd <= BCD_W'(bin[CNT_W-1]);
      sh <= bin << 1;
      left <= IW'(CNT_W - 1);
      done <= 1'b0;
    end else begin
      done <= left == IW'(1);
      if (left != '0) begin
        {bcd, sh} <= nxt;
        left <= left - 1'b1;
      end
    end
endmodule

// File: rtl/freq_seq_ctrl.sv
// freq_seq_ctrl: gated edge counter with BCD conversion and publish strobe; FREQ_SEQ_LZB_EN adds leading-zero blanking
module freq_seq_ctrl
  import freq_seq_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W = 14
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  IN,
  input  logic                  en,
  output logic [BCD_W-1:0]      bcd,
  output logic                  valid,
  output logic                  ovf,
  output logic                  busy,
  output logic [BCD_DIGITS-1:0] blank
);
  localparam int WIN_W = $clog2(GATE_CYCLES);
  state_t state, state_nxt;
  logic [WIN_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] conv;
  logic sync1, sync2, sync3, edge_r, ovf_s, ovf_l, last, done;
  assign last = win == WIN_W'(GATE_CYCLES - 1);
  // dropping en abandons the measurement from any state
  assign state_nxt = !en ? IDLE :
    state == IDLE ? GATE :
    state == GATE ? (last ? LATCH : GATE) :
    state == LATCH ? CONVERT :
    state == CONVERT ? (done ? PUBLISH : CONVERT) : GATE;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      {sync1, sync2, sync3, edge_r} <= '0;
      state <= IDLE;
      busy <= 1'b0;
      win <= '0;
      cnt <= '0;
      ovf_s <= 1'b0;
      ovf_l <= 1'b0;
    end else begin
      sync1 <= IN;
      sync2 <= sync1;
      sync3 <= sync2;
      edge_r <= sync2 & ~sync3;
      state <= state_nxt;
      busy <= state_nxt != IDLE;
      win <= state == GATE && !last ? win + 1'b1 : '0;
      if (state == LATCH) ovf_l <= ovf_s;
      if (state != GATE) begin
        cnt <= '0;
        ovf_s <= 1'b0;
      end else if (edge_r) begin
        if (cnt == CNT_W'(MAX_COUNT)) ovf_s <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
    end
  bin2bcd_seq #(.CNT_W(CNT_W)) u_conv (
    .CLK  (CLK),
    .reset(reset),
    .load (state == LATCH),
    .bin  (cnt),
    .bcd  (conv),
    .done (done)
  );
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      bcd <= '0;
      valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      valid <= state_nxt == PUBLISH;
      if (state_nxt == PUBLISH) begin
        bcd <= conv;
        ovf <= ovf_l;
      end
    end
`ifdef FREQ_SEQ_LZB_EN
  logic [BCD_DIGITS-1:0] dz;
  always_comb begin
    dz = '0;
    for (int i = 0; i < BCD_DIGITS; i++) dz[i] = conv[i*NIB_W +: NIB_W] == '0;
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) blank <= '0;
    else if (state_nxt == PUBLISH) blank <= {dz[3], &dz[3:2], &dz[3:1], 1'b0};
`else
  assign blank = '0;
`endif
endmodule

// File: tb/tb_freq_seq_ctrl.sv
// tb_freq_seq_ctrl: randomized bench checking two sequencer instances against a window/phase reference model
module tb_freq_seq_ctrl;
  localparam int G0 = 100;
  localparam int G1 = 20500;
`ifdef FREQ_SEQ_LZB_EN
  localparam logic [3:0] BLK_SMALL = 4'b1110;
`else
  localparam logic [3:0] BLK_SMALL = 4'b0000;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic in0 = 1'b0, en0 = 1'b0, in1 = 1'b0, en1 = 1'b0;
  logic [15:0] bcd0, bcd1;
  logic [3:0] blank0, blank1;
  logic valid0, valid1, ovf0, ovf1, busy0, busy1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  freq_seq_ctrl #(.GATE_CYCLES(G0), .CNT_W(14)) dut (
    .CLK(clk), .reset(reset), .IN(in0), .en(en0),
    .bcd(bcd0), .valid(valid0), .ovf(ovf0), .busy(busy0), .blank(blank0));
  freq_seq_ctrl #(.GATE_CYCLES(G1), .CNT_W(14)) dut_ovf (
    .CLK(clk), .reset(reset), .IN(in1), .en(en1),
    .bcd(bcd1), .valid(valid1), .ovf(ovf1), .busy(busy1), .blank(blank1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 1000) % 10 * 4096 + (v / 100) % 10 * 256 + (v / 10) % 10 * 16 + v % 10);
  endfunction
  function automatic logic [3:0] lzb(input int v);
`ifdef FREQ_SEQ_LZB_EN
    return {v < 1000, v < 100, v < 10, 1'b0};
`else
    return 4'b0000 & 4'(v);
`endif
  endfunction

  // Reference model: measurement phase counted from run start, period G+16,
  // an edge is a 0->1 step in the pin history seen 2..3 samples back.
  logic en_p[2], in_p[2];
  logic rst_p;
  bit run[2];
  int ph[2], cnt[2];
  logic [3:0] hist[2];
  logic [15:0] ebcd[2];
  logic [3:0] eblank[2];
  logic eovf[2], evalid[2];
  always @(posedge clk) begin
    en_p[0] = en0; en_p[1] = en1;
    in_p[0] = in0; in_p[1] = in1;
    rst_p = reset;
  end
  always @(negedge clk) begin
    int g, v;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? G0 : G1;
      hist[i] = {hist[i][2:0], in_p[i]};
      evalid[i] = 1'b0;
      if (!reset || !rst_p) begin
        run[i] = 1'b0;
        hist[i] = '0;
        ebcd[i] = '0;
        eovf[i] = 1'b0;
        eblank[i] = '0;
      end else begin
        if (!en_p[i]) run[i] = 1'b0;
        else if (!run[i]) begin
          run[i] = 1'b1;
          ph[i] = 0;
          cnt[i] = 0;
        end else begin
          ph[i]++;
          if (ph[i] == g + 16) begin
            ph[i] = 0;
            cnt[i] = 0;
          end
        end
        if (run[i] && ph[i] < g && hist[i][2] && !hist[i][3]) cnt[i]++;
        evalid[i] = run[i] && ph[i] == g + 15;
        if (evalid[i]) begin
          v = cnt[i] > 9999 ? 9999 : cnt[i];
          ebcd[i] = to_bcd(v);
          eovf[i] = cnt[i] > 9999;
          eblank[i] = lzb(v);
        end
      end
      check($sformatf("valid%0d", i), 32'(i == 0 ? valid0 : valid1), 32'(evalid[i]));
      check($sformatf("busy%0d", i), 32'(i == 0 ? busy0 : busy1), 32'(run[i]));
      check($sformatf("bcd%0d", i), 32'(i == 0 ? bcd0 : bcd1), 32'(ebcd[i]));
      check($sformatf("ovf%0d", i), 32'(i == 0 ? ovf0 : ovf1), 32'(eovf[i]));
      check($sformatf("blank%0d", i), 32'(i == 0 ? blank0 : blank1), 32'(eblank[i]));
    end
  end

  int mode0 = 1, per0 = 10, per1 = 2, tick = 0, t0 = 0;
  bit mode1 = 1'b0;
  task automatic step();
    @(posedge clk);
    #2;
    tick++;
    in0 = mode0 == 1 ? ((tick % per0) < per0 / 2) :
          mode0 == 2 ? 1'($urandom_range(0, 1)) :
          mode0 == 3 ? (tick >= t0 && tick < t0 + 28 && (tick - t0) % 4 == 0) : 1'b0;
    in1 = mode1 && ((tick % per1) < per1 / 2);
  endtask
  task automatic wait_valid(input int d, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(d != 0 ? valid1 : valid0) && n < bound);
    total++;
    if (!(d != 0 ? valid1 : valid0)) begin
      bad++;
      $display("FAIL wait_valid%0d: no valid within %0d cycles", d, bound);
    end
  endtask

  initial begin
    int n, vc;
    en0 = 1'b1;
    repeat (10) step();
    check("rst_bcd", 32'(bcd0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_valid", 32'(valid0), 0);
    reset = 1'b1;
    check("busy_at_release", 32'(busy0), 0);
    step();
    check("busy_rise", 32'(busy0), 1);
    // basic count: period-10 input, 10 edges per window
    wait_valid(0, 300, n);
    wait_valid(0, 200, n);
    check("basic_bcd", 32'(bcd0), 32'h0010);
    check("basic_ovf", 32'(ovf0), 0);
    wait_valid(0, 200, n);
    check("period", n, 116);
    check("basic_bcd2", 32'(bcd0), 32'h0010);
    // enable drop mid-window
    repeat (50) step();
    en0 = 1'b0;
    per0 = 20;
    step();
    check("drop_busy", 32'(busy0), 0);
    check("drop_bcd", 32'(bcd0), 32'h0010);
    vc = 0;
    repeat (150) begin
      step();
      vc += int'(valid0);
    end
    check("drop_no_valid", vc, 0);
    check("drop_hold_bcd", 32'(bcd0), 32'h0010);
    en0 = 1'b1;
    wait_valid(0, 200, n);
    check("restart_bcd", 32'(bcd0), 32'h0005);
    // reset on the 5th CONVERT cycle
    repeat (106) step();
    reset = 1'b0;
    #1;
    check("mid_rst_bcd", 32'(bcd0), 0);
    check("mid_rst_valid", 32'(valid0), 0);
    check("mid_rst_busy", 32'(busy0), 0);
    repeat (3) step();
    reset = 1'b1;
    vc = 0;
    repeat (110) begin
      step();
      vc += int'(valid0);
    end
    check("mid_rst_no_valid", vc, 0);
    // zero window, then a 7-pulse window
    mode0 = 0;
    wait_valid(0, 300, n);
    wait_valid(0, 200, n);
    check("zero_bcd", 32'(bcd0), 0);
    check("zero_blank", 32'(blank0), 32'(BLK_SMALL));
    mode0 = 3;
    t0 = tick + 10;
    wait_valid(0, 200, n);
    check("seven_bcd", 32'(bcd0), 32'h0007);
    check("seven_blank", 32'(blank0), 32'(BLK_SMALL));
    // random input with random enable drops
    mode0 = 2;
    repeat (6) begin
      repeat ($urandom_range(50, 300)) step();
      en0 = 1'b0;
      repeat ($urandom_range(1, 4)) step();
      en0 = 1'b1;
    end
    repeat (250) step();
    en0 = 1'b0;
    mode0 = 0;
    // overflow on the long-window instance
    mode1 = 1'b1;
    per1 = 2;
    en1 = 1'b1;
    repeat (20504) step();
    per1 = 4100;
    wait_valid(1, 100, n);
    check("ovf_bcd", 32'(bcd1), 32'h9999);
    check("ovf_flag", 32'(ovf1), 1);
    wait_valid(1, 20600, n);
    check("post_ovf_bcd", 32'(bcd1), 32'h0005);
    check("post_ovf_flag", 32'(ovf1), 0);
    en1 = 1'b0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_seq_ctrl.md
# freq_seq_ctrl

Measurement sequencer for the frequency-display path. It synchronizes the external `IN` signal and counts its rising edges over a fixed gate window. At the end of each window it latches the count and converts it to four BCD digits with an iterative shift-add-3 engine. It then publishes the digits with a one-cycle valid strobe to the 7-segment display controller and immediately opens the next window.

## Interface
- `GATE_CYCLES`, 100_000_000: gate window length in `CLK` cycles (1 s at 100 MHz); minimum 2.
- `CNT_W`, 14: edge-counter width; holds 0..9999.
- `CLK` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- `IN` input 1: asynchronous measured signal.
- `en` input 1: run enable; high means continuous measurement.
- `bcd` output 16: published result {thousands, hundreds, tens, ones}. Reset value 0.
- `valid` output 1: one-cycle strobe when `bcd` updates. Reset value 0.
- `ovf` output 1: published result saturated at 9999. Reset value 0.
- `busy` output 1: high in any state other than IDLE. Reset value 0.
- `blank` output 4: leading-zero blank mask, bit 3 = thousands. Reset value 0.

## Operation
- `IN` passes through a 2-FF synchronizer, then a registered edge detector. A rising edge is detected 3 cycles after it occurs at the pin.
- State machine: IDLE → GATE → LATCH → CONVERT → PUBLISH → GATE.
  - **IDLE:** counters clear. Moves to GATE when `en` is 1.
  - **GATE:** the window counter runs 0..GATE_CYCLES-1. A detected edge increments the edge count. The count saturates at 9999 and sets a sticky overflow bit. When the window counter reaches GATE_CYCLES-1, the state moves to LATCH. An edge detected in that final cycle is counted.
  - **LATCH:** copies the count and overflow bit into the converter and clears the edge count and overflow bit. Lasts 1 cycle.
  - **CONVERT:** runs CNT_W shift-add-3 iterations, one per cycle. Before each shift, add 3 to every nibble ≥ 5.
  - **PUBLISH:** loads `bcd`, `ovf` and `blank`, and pulses `valid` high for this cycle. Lasts 1 cycle. The next state is GATE if `en` = 1, else IDLE.
- Edges detected outside GATE are discarded. The dead time is CNT_W + 2 cycles per measurement.
- Deassert `en`: from GATE, LATCH or CONVERT, the block goes to IDLE on the next cycle. It does not publish, and `bcd`, `ovf` and `blank` keep their last values.
- Reasserting `en` starts a fresh window with the count at 0.
- Asserting `reset` in any state forces all outputs and state to their reset values asynchronously.
- Arithmetic:
  - The edge count is unsigned CNT_W bits and compares against the constant 9999. It never wraps.
  - The window counter is sized ⌈log2(GATE_CYCLES)⌉ bits.

## Timing
- Measurement period is GATE_CYCLES + CNT_W + 2 cycles.
- Latency from the end of GATE to `valid` is CNT_W + 2 cycles (LATCH, then CNT_W CONVERT cycles, then PUBLISH). With the default CNT_W, that is 16 cycles.
- `valid` is high for exactly 1 cycle per window. `bcd` stays stable from that cycle until the next PUBLISH.
- The first GATE cycle follows the cycle in which `en` is sampled high in IDLE.
- `busy` is registered and reflects the current state.
- There is no back-pressure; the consumer must capture on `valid`.

## Configuration
- `FREQ_SEQ_LZB_EN` defined:
  - `blank` bit i is 1 when digit i and all higher digits are 0.
  - The ones digit is never blanked. Example: value 7 gives `blank` = 4'b1110.
  - `blank` is computed in PUBLISH from the converted digits.
- `FREQ_SEQ_LZB_EN` undefined: `blank` is tied to 4'b0000 and no blank logic is synthesized.

## Structure
- Shared package `freq_seq_pkg` holds:
  - the state enum (IDLE, GATE, LATCH, CONVERT, PUBLISH);
  - `BCD_DIGITS` = 4;
  - `MAX_COUNT` = 9999;
  - the nibble width of 4.
- Sub-module `bin2bcd_seq` is the iterative converter.
  - Inputs: `CLK`, `reset`, `load`, `bin[CNT_W-1:0]`.
  - Outputs: `bcd[15:0]` and a `done` pulse after CNT_W cycles.
  - The parent FSM leaves CONVERT on `done`.

## Test plan
- **Reset:** hold `reset` low with `en` = 1 and `IN` toggling → `bcd` = 0, `valid` = 0, `ovf` = 0, `busy` = 0, `blank` = 0 throughout. After release, `busy` rises 1 cycle later.
- **Basic count:** GATE_CYCLES = 100, `IN` period 10 cycles, aligned so that exactly 10 rising edges fall in GATE → `valid` 16 cycles after GATE ends, `bcd` = 16'h0010, `ovf` = 0. Repeats every 116 cycles.
- **Overflow:** GATE_CYCLES = 20500, `IN` period 2 cycles (≈10250 edges) → `bcd` = 16'h9999, `ovf` = 1. The next window with 5 edges gives `bcd` = 16'h0005, `ovf` = 0.
- **Enable drop mid-GATE:** after a published 16'h0010, drop `en` at window cycle 50 → no `valid`, `bcd` stays 16'h0010, `busy` = 0 next cycle. Raise `en` → the next result counts only new-window edges.
- **Reset mid-CONVERT:** assert `reset` on the 5th CONVERT cycle → all outputs 0 in the same cycle, and no `valid` follows.
- **Leading-zero blanking:** 7 edges in a window → `bcd` = 16'h0007. `blank` = 4'b1110 with `FREQ_SEQ_LZB_EN`, 4'b0000 without. A count of 0 gives `blank` = 4'b1110 with the macro defined.
